// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP multiply-accumulate writer.
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        WB   = 2'd3
    } state_t;

    // Field positions inside the r18 control word.
    localparam int START_BIT = 0;
    localparam int DEST_LSB  = 1;
    localparam int DEST_MSB  = 5;
    localparam int SHIFT_LSB = 6;
    localparam int SHIFT_MSB = 10;

    localparam int          NUM_REGS = 19;
    localparam logic [31:0] SAT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN  = 32'h8000_0000;

    // Clamp a signed 64-bit value into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [63:0] v);
        if (v > $signed(64'h0000_0000_7FFF_FFFF))
            return SAT_MAX;
        else if (v < $signed(64'hFFFF_FFFF_8000_0000))
            return SAT_MIN;
        else
            return v[31:0];
    endfunction

endpackage

// File: rtl/seq_mul32.sv
// 32x32 unsigned radix-2 shift-add multiplier, one operand bit per cycle.
// start loads the operands; done is high during the final step, so the
// 64-bit product is complete on the cycle after done.
module seq_mul32 #(
    parameter int STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [63:0] product
);

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [5:0]  cnt;
    logic        running;

    assign done    = running && (cnt == 6'(STEPS - 1));
    assign product = prod;

    // Load on start, then add the shifted multiplicand for every set multiplier bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {32'b0, a};
            mplier  <= b;
            prod    <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0])
                prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/dsp_mac_writer.sv
// Signed multiply-accumulate engine fed by the r16/r17/r18 register window.
// The saturated, shifted accumulator is written back through the register
// file port using a req/gnt handshake; no write happens without a grant.
module dsp_mac_writer
    import dsp_pkg::*;
#(
    parameter int MUL_STEPS = 32,
    parameter int NUM_REGS  = dsp_pkg::NUM_REGS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] r16,
    input  logic [31:0] r17,
    input  logic [31:0] r18,
    input  logic        acc_clr,
    input  logic        wb_gnt,
    output logic        wb_req,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t             state;
    logic               start_prev;
    logic               start_edge;
    logic [4:0]         dest_q;
    logic [4:0]         shift_q;
    logic               neg_q;
    logic signed [63:0] acc;

    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic               mul_start;
    logic               mul_done;
    logic [63:0]        mul_prod;
    logic signed [63:0] product_s;
    logic signed [63:0] acc_sum;
    logic [31:0]        sat_result;
    logic               unused_r18;

    // Control bits above the shift field carry no meaning here.
    assign unused_r18 = &{1'b0, r18[31:SHIFT_MSB+1]};

    assign start_edge = r18[START_BIT] & ~start_prev;
    assign mul_start  = (state == IDLE) && start_edge;

    // Operand magnitudes, product sign fix-up, accumulate and saturate.
    always_comb begin
        a_mag      = r16[31] ? (~r16 + 32'd1) : r16;
        b_mag      = r17[31] ? (~r17 + 32'd1) : r17;
        product_s  = neg_q ? -$signed(mul_prod) : $signed(mul_prod);
        acc_sum    = acc + product_s;
        sat_result = sat32(acc_sum >>> shift_q);
    end

    seq_mul32 #(
        .STEPS(MUL_STEPS)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a_mag),
        .b      (b_mag),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Job FSM: edge-launched multiply, accumulate, then granted write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            dest_q     <= '0;
            shift_q    <= '0;
            neg_q      <= 1'b0;
            acc        <= '0;
            wb_req     <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            start_prev <= r18[START_BIT];
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear takes effect before the product of a coinciding job is added.
                    if (acc_clr)
                        acc <= '0;
                    if (start_edge) begin
                        dest_q  <= r18[DEST_MSB:DEST_LSB];
                        shift_q <= r18[SHIFT_MSB:SHIFT_LSB];
                        neg_q   <= r16[31] ^ r17[31];
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mul_done)
                        state <= ACC;
                end
                ACC: begin
                    acc <= acc_sum;
                    if (dest_q == 5'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (int'(dest_q) >= NUM_REGS) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wb_req  <= 1'b1;
                        wb_addr <= dest_q;
                        wb_data <= sat_result;
                        state   <= WB;
                    end
                end
                WB: begin
                    if (wb_gnt) begin
                        wb_req <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_writer.sv
// Directed bench for dsp_mac_writer: a driver issues jobs and pushes the
// expected completion record; a monitor pops and compares on every done.
module tb_dsp_mac_writer;

    localparam int EW = 39; // {wrote, err, addr[4:0], data[31:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] r16 = '0;
    logic [31:0] r17 = '0;
    logic [31:0] r18 = '0;
    logic        acc_clr = 1'b0;
    logic        wb_gnt = 1'b0;
    logic        wb_req;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];

    dsp_mac_writer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .r16    (r16),
        .r17    (r17),
        .r18    (r18),
        .acc_clr(acc_clr),
        .wb_gnt (wb_gnt),
        .wb_req (wb_req),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor / scoreboard
    logic        seen_req = 1'b0;
    logic [4:0]  cap_addr = '0;
    logic [31:0] cap_data = '0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            seen_req = 1'b0;
        end else begin
            if (wb_req && !seen_req) begin
                seen_req = 1'b1;
                cap_addr = wb_addr;
                cap_data = wb_data;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wrote", 64'(seen_req), 64'(e[38]));
                    check("err", 64'(err), 64'(e[37]));
                    if (e[38]) begin
                        check("wb_addr", 64'(cap_addr), 64'(e[36:32]));
                        check("wb_data", 64'(cap_data), 64'(e[31:0]));
                    end
                end
                seen_req = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic pulse_clr();
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] dest, input logic [4:0] shift,
                           input int gnt_delay, input logic [31:0] exp_data,
                           input logic exp_wrote, input logic exp_err,
                           input bit toggle, input bit clr_start);
        int c;
        wb_gnt = (gnt_delay == 0);
        exp_q.push_back({exp_wrote, exp_err, dest, exp_data});
        r16 = a;
        r17 = b;
        r18 = {21'b0, shift, dest, 1'b1};
        acc_clr = clr_start;
        @(negedge clk);
        c = 1;
        acc_clr = 1'b0;
        check("busy_t1", 64'(busy), 64'd1);
        r18[0] = 1'b0;
        while (!(wb_req || done) && c < 80) begin
            if (toggle) begin
                r18[0] = (c < 20) ? c[0] : 1'b0;
                r16 = 32'd100;
            end
            @(negedge clk);
            c++;
        end
        if (exp_wrote) begin
            check("req_latency", 64'(c), 64'd34);
            for (int i = 0; i < gnt_delay; i++) begin
                check("hold_req", 64'(wb_req), 64'd1);
                check("hold_addr", 64'(wb_addr), 64'(dest));
                check("hold_data", 64'(wb_data), 64'(exp_data));
                check("hold_no_done", 64'(done), 64'd0);
                @(negedge clk);
                c++;
            end
            wb_gnt = 1'b1;
            @(negedge clk);
            c++;
            check("done_latency", 64'(c), 64'(35 + gnt_delay));
            check("done_pulse", 64'(done), 64'd1);
            check("busy_after", 64'(busy), 64'd0);
            check("req_dropped", 64'(wb_req), 64'd0);
        end else begin
            check("suppressed_done_latency", 64'(c), 64'd34);
            check("suppressed_done", 64'(done), 64'd1);
            check("suppressed_busy", 64'(busy), 64'd0);
        end
        wb_gnt = 1'b0;
        r16 = '0;
        r17 = '0;
        r18 = '0;
        repeat (3) @(negedge clk);
        if (toggle)
            check("no_extra_job", 64'(busy), 64'd0);
    endtask

    // Stimulus
    initial begin
        #1;
        check("rst_wb_req", 64'(wb_req), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // acc: 12
        run_job(32'd3, 32'd4, 5'd5, 5'd0, 0, 32'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 12 - 10 = 2
        run_job(32'hFFFF_FFFE, 32'd5, 5'd5, 5'd0, 0, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: -10
        pulse_clr();
        run_job(32'hFFFF_FFFE, 32'd5, 5'd5, 5'd0, 0, 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 2^32 - 10 saturates high
        run_job(32'h4000_0000, 32'd4, 5'd6, 5'd0, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 256, >>> 4 = 16
        pulse_clr();
        run_job(32'h0000_0100, 32'd1, 5'd7, 5'd4, 0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 256 - 2^32 saturates low
        run_job(32'h8000_0000, 32'd2, 5'd8, 5'd0, 0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 5, dest 0 suppressed
        pulse_clr();
        run_job(32'd5, 32'd1, 5'd0, 5'd0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // acc: 12, dest 20 illegal
        run_job(32'd7, 32'd1, 5'd20, 5'd0, 0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // acc: 12 shows both suppressed jobs accumulated
        run_job(32'd0, 32'd0, 5'd3, 5'd0, 0, 32'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        // acc: 18, grant withheld 3 cycles, start/r16 toggled during MUL
        run_job(32'd2, 32'd3, 5'd7, 5'd0, 3, 32'd18, 1'b1, 1'b0, 1'b1, 1'b0);
        // clear with start: acc = -256, >>> 4 = -16
        run_job(32'hFFFF_FF00, 32'd1, 5'd9, 5'd4, 0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-MUL aborts with no write and zeroes the accumulator.
        r16 = 32'd9;
        r17 = 32'd9;
        r18 = {21'b0, 5'd0, 5'd5, 1'b1};
        wb_gnt = 1'b1;
        repeat (10) @(negedge clk);
        r18 = '0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_wb_req", 64'(wb_req), 64'd0);
        check("midrst_wb_addr", 64'(wb_addr), 64'd0);
        check("midrst_wb_data", 64'(wb_data), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        wb_gnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_job(32'd3, 32'd4, 5'd5, 5'd0, 0, 32'd12, 1'b1, 1'b0, 1'b0, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_writer.md
# dsp_mac_writer

Sequential signed multiply-accumulate engine that consumes the DSP register window (r16 operand A, r17 operand B, r18 control) exported by the register file and writes its saturated result back through the register file's write port. It sits beside the core datapath, requests the rd write port with a req/gnt handshake, and never writes without a grant. One job runs at a time. A rising edge on the start bit r18[0] launches the job.

## Interface
Parameters:
- MUL_STEPS, 32: shift-add iterations, one per operand bit (fixed at 32 for 32-bit operands).
- NUM_REGS, 19: register file depth; destinations at or above this value are illegal.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r16  in  32  operand A, signed.
- r17  in  32  operand B, signed.
- r18  in  32  control word: [0] start, [5:1] dest register, [10:6] right-shift amount (0–31).
- acc_clr  in  1  clears the accumulator; honoured only in IDLE.
- wb_gnt  in  1  write-port grant from the core.
- wb_req  out  1  write-port request.
- wb_addr  out  5  destination register.
- wb_data  out  32  result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a job ends.
- err  out  1  one-cycle pulse with done when dest ≥ NUM_REGS.

## Operation
- **Start detection:** start_prev register samples r18[0] every cycle, including while busy. A start edge is r18[0] & ~start_prev. An edge while busy is ignored; it is not queued.
- **Operand latch:** on an accepted edge, latch r16, r17, dest and shift. Later register changes do not affect the running job.
- **States:**
  - IDLE → MUL on an accepted start edge.
  - MUL: 32 cycles of radix-2 shift-add on the operand magnitudes, yielding a 64-bit unsigned product. The sign (signA ^ signB) is applied at the end, giving a 64-bit two's-complement product. MUL → ACC when the step count reaches 31.
  - ACC: acc <= acc + product, 64-bit, wrapping on overflow. Result = sat32(acc >>> shift), arithmetic shift.
    - Result above 0x7FFFFFFF clamps to 0x7FFFFFFF.
    - Result below −2^31 clamps to 0x80000000.
    - ACC → WB if 1 ≤ dest < 19.
    - ACC → IDLE with done=1 if dest == 0 (write suppressed, no error).
    - ACC → IDLE with done=1 and err=1 if dest ≥ 19 (write suppressed).
    - The accumulator is updated in every one of these cases.
  - WB: hold wb_req=1 with wb_addr/wb_data stable until wb_gnt is sampled high. On that edge: wb_req drops, done pulses, state → IDLE.
- **Grant rules:** wb_gnt outside WB is ignored. wb_gnt in the same cycle wb_req first rises completes the transfer that cycle.
- **Accumulator clear:** acc_clr in IDLE sets acc to 0. If it coincides with an accepted start edge, the clear applies first and the job accumulates from 0. acc_clr while busy is ignored.
- **Persistence:** the accumulator persists across jobs until acc_clr or reset.

## Timing
- **Reset values:** wb_req=0, wb_addr=0, wb_data=0, busy=0, done=0, err=0. Internally acc=0, start_prev=0, state IDLE.
- **Reset mid-job:** reset at any point aborts the job immediately, with no partial write.
- **Start edge:** sampled at cycle T, where r18[0]=1 and start_prev=0.
  - busy=1 from T+1.
  - MUL spans T+1..T+32.
  - ACC at T+33.
  - wb_req=1 from T+34.
- **Zero-latency grant:** if wb_gnt=1 at T+34, done=1 in cycle T+35 and busy=0 at T+35.
- **Suppressed write** (dest illegal or 0): done/err at T+34.
- **Output registers:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared package dsp_pkg:**
  - state enum {IDLE, MUL, ACC, WB}.
  - r18 field positions: START_BIT=0, DEST_LSB=1, DEST_MSB=5, SHIFT_LSB=6, SHIFT_MSB=10.
  - NUM_REGS=19, SAT_MAX=32'h7FFFFFFF, SAT_MIN=32'h80000000.
- **Sub-module seq_mul32:** 32×32 unsigned shift-add multiplier with start/done and a 64-bit product, driven by the MUL state.
- **Top level** holds the FSM, start edge detector, accumulator, saturation and write-back handshake.

## Test plan
- r16=3, r17=4, r18 dest=5, shift=0, start 0→1; wb_gnt tied high → wb_addr=5, wb_data=12, wb_req at T+34, done at T+35.
- Second job without acc_clr, r16=−2, r17=5 → wb_data=2 (12−10). Then acc_clr in IDLE followed by the same job → wb_data=0xFFFFFFF6.
- Saturation and shift:
  - r16=0x40000000, r17=4, shift=0 → wb_data=0x7FFFFFFF.
  - With a cleared acc, r16=0x100, r17=1, shift=4 → wb_data=0x10.
  - r16=0x80000000, r17=2 → wb_data=0x80000000.
- dest=0 → no wb_req, done at T+34, err=0. dest=20 → no wb_req, done=1 and err=1 at T+34, acc still updated.
- wb_gnt withheld for 3 cycles in WB → wb_req/wb_addr/wb_data stable all 3 cycles, done one cycle after the grant. Toggling r18[0] and r16 during MUL → no new job, result unchanged.
- rst_n low at T+10 (mid-MUL) → all outputs 0 asynchronously, acc=0. After release, a fresh job with r16=3, r17=4, dest=5 → wb_data=12.
